// File: rtl/fc_requant_relu.sv
// fc_requant_relu: requantizes MAC accumulators (scale, round, ReLU, saturate) over valid/ready and pulses done per layer
module fc_requant_relu #(
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int MULT_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int CNT_WIDTH   = 10
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_run,
    input  logic [CNT_WIDTH-1:0]        i_num_out,
    input  logic [MULT_WIDTH-1:0]       i_mult,
    input  logic [SHIFT_WIDTH-1:0]      i_shift,
    input  logic                        i_relu_en,
    input  logic                        i_valid,
    input  logic [ACC_WIDTH-1:0]        i_acc,
    output logic                        o_ready,
    output logic                        o_valid,
    output logic signed [OUT_WIDTH-1:0] o_data,
    input  logic                        i_ready,
    output logic                        o_done
);
    localparam int PW = ACC_WIDTH + MULT_WIDTH + 1;
    localparam logic signed [PW:0] MAX_V = (PW+1)'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [PW:0] MIN_V = -MAX_V - (PW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CNT_WIDTH-1:0]    num_out, in_cnt, out_cnt;
    logic [MULT_WIDTH-1:0]   mult;
    logic [SHIFT_WIDTH-1:0]  shift;
    logic                    relu_en;
    logic                    s1_valid;
    logic signed [PW-1:0]    s1_prod;
    logic                    en, in_hs, out_hs, last_out;
    logic signed [PW:0]      half, rnd, r, rl;
    logic signed [OUT_WIDTH-1:0] sat;

    assign en       = ~o_valid | i_ready;
    assign o_ready  = en & (state == RUN) & (in_cnt < num_out) & ~i_run;
    assign in_hs    = i_valid & o_ready;
    assign out_hs   = o_valid & i_ready;
    assign last_out = out_hs & (out_cnt == num_out - CNT_WIDTH'(1));
    assign o_done   = (state == DONE) & ~i_run;

    // Next state: a run request restarts from any state; an empty layer finishes immediately
    always_comb begin
        state_nxt = state;
        if (i_run)
            state_nxt = RUN;
        else if (state == RUN && (num_out == '0 || last_out))
            state_nxt = DONE;
        else if (state == DONE)
            state_nxt = IDLE;
    end

    // Round half up, optional ReLU, saturate; one guard bit keeps the rounding add from overflowing
    always_comb begin
        half = (shift == '0) ? '0 : (PW+1)'(1) <<< (shift - SHIFT_WIDTH'(1));
        rnd  = $signed({s1_prod[PW-1], s1_prod}) + half;
        r    = rnd >>> shift;
        rl   = (relu_en && r[PW]) ? '0 : r;
        sat  = (rl > MAX_V) ? MAX_V[OUT_WIDTH-1:0] :
               (rl < MIN_V) ? MIN_V[OUT_WIDTH-1:0] : rl[OUT_WIDTH-1:0];
    end

    // State, layer configuration and handshake counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            num_out <= '0;
            mult    <= '0;
            shift   <= '0;
            relu_en <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (i_run) begin
                num_out <= i_num_out;
                mult    <= i_mult;
                shift   <= i_shift;
                relu_en <= i_relu_en;
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (in_hs)
                    in_cnt <= in_cnt + CNT_WIDTH'(1);
                if (out_hs)
                    out_cnt <= out_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Two-stage pipeline: scale multiply, then requantize into the output register; frozen on stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
        end else if (i_run) begin
            s1_valid <= 1'b0;
            o_valid  <= 1'b0;
        end else if (en) begin
            s1_valid <= in_hs;
            if (in_hs)
                s1_prod <= PW'($signed(i_acc)) * PW'($signed({1'b0, mult}));
            o_valid <= s1_valid;
            if (s1_valid)
                o_data <= sat;
        end
    end
endmodule

// File: tb/tb_fc_requant_relu.sv
// tb_fc_requant_relu: vector table, directed handshake sequences and randomized layers against a reference model
module tb_fc_requant_relu;
    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_run;
    logic [9:0]        i_num_out;
    logic [15:0]       i_mult;
    logic [4:0]        i_shift;
    logic              i_relu_en;
    logic              i_valid;
    logic [31:0]       i_acc;
    logic              o_ready;
    logic              o_valid;
    logic signed [7:0] o_data;
    logic              i_ready;
    logic              o_done;

    fc_requant_relu dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_out(i_num_out),
        .i_mult(i_mult), .i_shift(i_shift), .i_relu_en(i_relu_en),
        .i_valid(i_valid), .i_acc(i_acc), .o_ready(o_ready), .o_valid(o_valid),
        .o_data(o_data), .i_ready(i_ready), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int mult;
        int shift;
        int relu;
        int exp;
    } vec_t;

    int     compared = 0;
    int     mismatched = 0;
    int     done_seen = 0;
    longint exp_q[$];
    int     acc_cnt, out_cnt, m_num, m_mult, m_shift;
    bit     m_relu, active, zero_pend, done_exp, stall_prev;
    longint prev_data;

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requantization written straight from the arithmetic rules on 64-bit integers
    function automatic longint ref_q(input longint acc, input longint mult, input int sh, input bit relu);
        longint p, r;
        p = acc * mult;
        r = (sh == 0) ? p : ((p + (longint'(1) << (sh - 1))) >>> sh);
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        acc_cnt = 0; out_cnt = 0; m_num = 0; m_mult = 0; m_shift = 0;
        m_relu = 0; active = 0; zero_pend = 0; done_exp = 0; stall_prev = 0; prev_data = 0;
    endtask

    // One clock cycle: sample just after the inputs settle, check against the model, advance it
    task automatic tick();
        bit ihs, ohs;
        #1;
        chk("o_done", o_done, longint'(done_exp && !i_run));
        chk("o_ready", o_ready, longint'(active && (!o_valid || i_ready) && acc_cnt < m_num && !i_run));
        if (stall_prev) begin
            chk("stall_valid", o_valid, 1);
            chk("stall_data", o_data, prev_data);
        end
        if (o_done) done_seen++;
        ihs = i_valid && o_ready;
        ohs = o_valid && i_ready;
        if (ohs && !i_run) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_out: got o_data=%0d, expected no output", o_data);
            end else
                chk("o_data", o_data, exp_q.pop_front());
        end
        done_exp = 0;
        if (i_run) begin
            exp_q.delete();
            acc_cnt = 0; out_cnt = 0;
            m_num = int'(i_num_out); m_mult = int'(i_mult); m_shift = int'(i_shift); m_relu = i_relu_en;
            active = 1;
            zero_pend = (i_num_out == 0);
        end else begin
            if (ihs) begin
                exp_q.push_back(ref_q(longint'($signed(i_acc)), longint'(m_mult), m_shift, m_relu));
                acc_cnt++;
            end
            if (ohs) out_cnt++;
            if (active && (zero_pend || (ohs && out_cnt == m_num))) begin
                active = 0;
                done_exp = 1;
            end
            zero_pend = 0;
        end
        stall_prev = o_valid && !i_ready && !i_run;
        prev_data = o_data;
        @(negedge clk);
    endtask

    task automatic do_run(input int num, input int mult, input int sh, input bit relu);
        i_run = 1; i_num_out = 10'(num); i_mult = 16'(mult); i_shift = 5'(sh); i_relu_en = relu;
        i_valid = 0;
        tick();
        i_run = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        int   vals[$];
        int   d0, cyc;
        tbl.push_back('{100, 1, 0, 0, 100});
        tbl.push_back('{1000, 1, 0, 0, 127});
        tbl.push_back('{-1000, 1, 0, 0, -128});
        tbl.push_back('{100, 1, 0, 1, 100});
        tbl.push_back('{1000, 1, 0, 1, 127});
        tbl.push_back('{-1000, 1, 0, 1, 0});
        tbl.push_back('{5, 3, 2, 0, 4});
        tbl.push_back('{-5, 3, 2, 0, -4});
        tbl.push_back('{2, 3, 2, 0, 2});
        tbl.push_back('{6, 1, 2, 0, 2});
        tbl.push_back('{-6, 1, 2, 0, -1});
        tbl.push_back('{3, 1, 1, 0, 2});
        tbl.push_back('{-1, 1, 1, 0, 0});
        tbl.push_back('{32'sh8000_0000, 65535, 31, 0, -128});
        tbl.push_back('{32'sh7fff_ffff, 65535, 31, 0, 127});
        tbl.push_back('{200, 32768, 16, 0, 100});
        tbl.push_back('{-129, 1, 0, 1, 0});
        tbl.push_back('{-129, 1, 0, 0, -128});

        reset_n = 0; i_run = 0; i_num_out = 0; i_mult = 0; i_shift = 0; i_relu_en = 0;
        i_valid = 0; i_acc = 0; i_ready = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_ready", o_ready, 0);
        chk("rst_o_done", o_done, 0);
        reset_n = 1;
        tick();

        // Single-result layers: exact latency, value and done pulse
        foreach (tbl[i]) begin
            do_run(1, tbl[i].mult, tbl[i].shift, tbl[i].relu[0]);
            i_valid = 1; i_acc = tbl[i].acc; i_ready = 1;
            #1 chk("tbl_ready", o_ready, 1);
            tick();
            i_valid = 0;
            #1 chk("tbl_early_valid", o_valid, 0);
            tick();
            #1 chk("tbl_valid", o_valid, 1);
            chk($sformatf("tbl_data[%0d]", i), o_data, tbl[i].exp);
            tick();
            #1 chk("tbl_done", o_done, 1);
            tick();
        end

        // Four back-to-back results, a refused fifth input, done one cycle after the last output
        do_run(4, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            i_valid = (k <= 4); i_acc = 10 * (k + 1); i_ready = 1;
            #1;
            chk("t4_ready", o_ready, longint'(k < 4));
            chk("t4_valid", o_valid, longint'(k >= 2 && k <= 5));
            chk("t4_done", o_done, longint'(k == 6));
            tick();
        end
        i_valid = 0;

        // Downstream stall for three cycles with a result waiting
        do_run(3, 1, 0, 0);
        vals = '{10, 20, 30};
        d0 = done_seen;
        for (int k = 0; k < 12; k++) begin
            i_valid = (vals.size() > 0);
            i_acc = (vals.size() > 0) ? vals[0] : 0;
            i_ready = !(k >= 2 && k <= 4);
            #1;
            if (k >= 2 && k <= 4) begin
                chk("t5_valid", o_valid, 1);
                chk("t5_data", o_data, 10);
                chk("t5_ready", o_ready, 0);
            end
            if (i_valid && o_ready) void'(vals.pop_front());
            tick();
        end
        chk("t5_done_count", done_seen - d0, 1);
        chk("t5_pending", exp_q.size() + vals.size(), 0);

        // Restart with two results in flight, new empty layer
        do_run(4, 1, 0, 0);
        i_ready = 1; i_valid = 1; i_acc = 7; tick();
        i_acc = 8; tick();
        i_valid = 0; i_ready = 0;
        i_run = 1; i_num_out = 0; i_mult = 2;
        #1 chk("t6_valid_before", o_valid, 1);
        chk("t6_ready_run", o_ready, 0);
        tick();
        i_run = 0;
        #1 chk("t6_flushed", o_valid, 0);
        chk("t6_ready", o_ready, 0);
        chk("t6_no_done_yet", o_done, 0);
        tick();
        #1 chk("t6_done", o_done, 1);
        tick();
        #1 chk("t6_done_once", o_done, 0);
        tick();

        // New configuration takes effect after the restart
        do_run(1, 2, 0, 0);
        i_valid = 1; i_acc = 7; i_ready = 1; tick();
        i_valid = 0; tick();
        #1 chk("t6_new_cfg", o_data, 14);
        tick(); tick();

        // Randomized layers with random valid/ready traffic
        for (int l = 0; l < 10; l++) begin
            do_run($urandom_range(1, 12),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 8),
                   $urandom_range(0, 31), 1'($urandom_range(0, 1)));
            d0 = done_seen;
            cyc = 0;
            while (done_seen == d0 && cyc < 400) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_acc = 32'(int'($urandom) >>> $urandom_range(0, 31));
                i_ready = ($urandom_range(0, 3) != 0);
                tick();
                cyc++;
            end
            if (done_seen == d0) begin
                compared++;
                mismatched++;
                $display("FAIL rand_layer_timeout: layer %0d got no done after %0d cycles", l, cyc);
            end
            for (int k = 0; k < 3; k++) begin
                i_valid = 1'($urandom_range(0, 1));
                i_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end

        // Asynchronous reset in the middle of a layer
        do_run(5, 1, 0, 0);
        i_ready = 1; i_valid = 1; i_acc = 33; tick();
        i_acc = 44; tick();
        i_valid = 0; i_ready = 0;
        #3 reset_n = 0;
        #1;
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_o_data", o_data, 0);
        chk("mid_rst_o_ready", o_ready, 0);
        chk("mid_rst_o_done", o_done, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            i_valid = 1; i_ready = 1;
            #1 chk("post_rst_valid", o_valid, 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
